pipeline_sequencer: RTL and testbench
=====================================

# pipeline_sequencer

Central control FSM for the 5-stage RISC-V pipeline that shares the single-ported unified memory between instruction fetch (IF) and data access (MEM). Each pipeline advance takes one fetch slot, plus one data slot when the instruction in EX/MEM is a load or store. The block also inserts load-use bubbles, flushes on taken branches, latches halt, and keeps saturating performance counters. It drives the PC, IF/ID and downstream pipeline-register enables and the memory address-mux select.

## Interface
Parameters:
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_ready  in  1  memory finished the current access this cycle.
- ex_mem_mem_read  in  1  instruction in EX/MEM is a load.
- ex_mem_mem_write  in  1  instruction in EX/MEM is a store.
- id_ex_mem_read  in  1  instruction in ID/EX is a load.
- id_ex_rd  in  5  destination register of the ID/EX instruction.
- if_id_rs1, if_id_rs2  in  5 each  source registers of the IF/ID instruction.
- branch_taken  in  1  taken branch/jump resolved in EX/MEM.
- halt_req  in  1  ecall/ebreak/fence decoded.
- mem_req  out  1  memory access request.
- mem_sel  out  1  address mux select: 0 = PC (fetch), 1 = EX/MEM ALU result (data).
- mem_we  out  1  memory write enable.
- pc_en  out  1  PC load enable.
- if_id_en  out  1  IF/ID register enable.
- pipe_en  out  1  ID/EX, EX/MEM and MEM/WB register enable.
- id_ex_bubble  out  1  load zeros (NOP) into ID/EX instead of the decoded values.
- flush  out  1  clear IF/ID and ID/EX on this advance.
- halted  out  1  sequencer is in the HALTED state.
- wait_cnt  out  CNT_W  cycles with mem_req=1 and mem_ready=0.
- bubble_cnt  out  CNT_W  load-use bubbles inserted.

## Operation
- States: BOOT (reset state), FETCH, DATA, HALTED.
- BOOT: all outputs 0. Unconditionally goes to FETCH on the next edge.
- FETCH: mem_req=1, mem_sel=0, mem_we=0.
  - mem_ready=0: stay in FETCH.
  - mem_ready=1 and (ex_mem_mem_read | ex_mem_mem_write): go to DATA. No advance yet; the IF/ID register does not capture.
  - mem_ready=1, no data access pending: advance this cycle.
- DATA: mem_req=1, mem_sel=1, mem_we=ex_mem_mem_write.
  - mem_ready=0: stay in DATA.
  - mem_ready=1: advance this cycle, then go to FETCH.
  - The fetched instruction from the preceding FETCH slot is held by the memory-output latch owned by the IF stage, not by this block.
- Advance cycle (combinational, only in the cycle the advance occurs):
  - pipe_en=1.
  - load_use = id_ex_mem_read & (id_ex_rd != 0) & ((id_ex_rd == if_id_rs1) | (id_ex_rd == if_id_rs2)).
  - If branch_taken=1: pc_en=1, if_id_en=1, flush=1, id_ex_bubble=0. Branch takes priority; load_use and halt_req are ignored.
  - Else if load_use=1: pc_en=0, if_id_en=0, id_ex_bubble=1, and bubble_cnt increments.
  - Else: pc_en=1, if_id_en=1.
- In every non-advance cycle, pc_en, if_id_en, pipe_en, id_ex_bubble and flush are all 0.
- Halt: if halt_req=1 on an advance with branch_taken=0 and load_use=0, the advance completes and the next state is HALTED. If load_use=1, halt_req is re-evaluated on the next advance.
- HALTED: all enables 0, mem_req=0, halted=1. Exits only through rst.
- Counters saturate at all-ones and never wrap.
  - wait_cnt increments in FETCH or DATA whenever mem_ready=0.
  - Both counters reset to 0.

## Timing
- Reset: state=BOOT immediately on rst assertion, regardless of clk. All outputs are 0 while rst=1 and in the BOOT cycle after release. The first mem_req=1 appears in the second cycle after rst deasserts.
- Reset mid-access aborts the access. mem_req drops combinationally with rst.
- mem_req, mem_sel and halted are Moore outputs (state only).
  - mem_we depends on state and ex_mem_mem_write.
  - Enables, bubble and flush are Mealy on mem_ready.
- Minimum advance period:
  - 1 cycle with no data access and zero-wait memory (mem_ready high in FETCH).
  - 2 cycles with a load/store.
  - Plus one cycle per wait cycle.
- The pipeline-register inputs sampled here (ex_mem_*, id_ex_*, if_id_*, branch_taken, halt_req) only change on an advance edge, so they are stable across the FETCH to DATA sequence.
- mem_ready is ignored in BOOT and HALTED.

## Test plan
- Reset release, mem_ready held at 1, no loads or stores → BOOT for 1 cycle, then pc_en/pipe_en=1 every cycle; wait_cnt=0.
- Load in EX/MEM, mem_ready=1 → cycle n: mem_sel=0, no advance. Cycle n+1: mem_sel=1, mem_we=0, advance. Store variant: mem_we=1 in cycle n+1 only.
- mem_ready low for 3 cycles in DATA → state holds, mem_req stays 1, wait_cnt increments by exactly 3, single advance.
- id_ex_mem_read=1, id_ex_rd=5, if_id_rs2=5 → on the advance: pc_en=0, if_id_en=0, id_ex_bubble=1, bubble_cnt=1. Same with id_ex_rd=0 → no bubble.
- branch_taken=1 together with load_use=1 and halt_req=1 → flush=1, pc_en=1, no bubble, no halt. Next advance with halt_req=1 only → HALTED; mem_req stays 0 until rst.
- Preload wait_cnt to 0xFFFE via long stalls, then 3 more wait cycles → wait_cnt=0xFFFF, held. Assert rst mid-DATA → counters 0, state BOOT asynchronously.

Source files
------------

// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - memory-slot sequencer and hazard control for the 5-stage pipeline
module pipeline_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_ready,
    input  logic             ex_mem_mem_read,
    input  logic             ex_mem_mem_write,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rd,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic             branch_taken,
    input  logic             halt_req,
    output logic             mem_req,
    output logic             mem_sel,
    output logic             mem_we,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             pipe_en,
    output logic             id_ex_bubble,
    output logic             flush,
    output logic             halted,
    output logic [CNT_W-1:0] wait_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        DATA   = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    logic data_pending;
    logic load_use;
    logic advance;
    logic wait_cycle;
    logic bubble_ins;

    assign data_pending = ex_mem_mem_read | ex_mem_mem_write;
    assign load_use = id_ex_mem_read & (id_ex_rd != 5'd0) &
                      ((id_ex_rd == if_id_rs1) | (id_ex_rd == if_id_rs2));

    // State register; reset aborts any in-flight access immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; enables only pulse in the advance cycle
    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_sel      = 1'b0;
        mem_we       = 1'b0;
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        pipe_en      = 1'b0;
        id_ex_bubble = 1'b0;
        flush        = 1'b0;
        halted       = 1'b0;
        advance      = 1'b0;
        wait_cycle   = 1'b0;
        bubble_ins   = 1'b0;

        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                mem_req    = 1'b1;
                wait_cycle = ~mem_ready;
                if (mem_ready) begin
                    if (data_pending) begin
                        state_d = DATA;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            DATA: begin
                mem_req    = 1'b1;
                mem_sel    = 1'b1;
                mem_we     = ex_mem_mem_write;
                wait_cycle = ~mem_ready;
                if (mem_ready) begin
                    advance = 1'b1;
                    state_d = FETCH;
                end
            end
            HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        // Branch beats load-use, which in turn defers any halt to a later advance
        if (advance) begin
            pipe_en = 1'b1;
            if (branch_taken) begin
                pc_en    = 1'b1;
                if_id_en = 1'b1;
                flush    = 1'b1;
            end else if (load_use) begin
                id_ex_bubble = 1'b1;
                bubble_ins   = 1'b1;
            end else begin
                pc_en    = 1'b1;
                if_id_en = 1'b1;
                if (halt_req) begin
                    state_d = HALTED;
                end
            end
        end
    end

    // Saturating counter next-state
    always_comb begin
        wait_cnt_d   = wait_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (wait_cycle && (wait_cnt_q != CNT_MAX)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
        if (bubble_ins && (bubble_cnt_q != CNT_MAX)) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    // Performance counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q   <= '0;
            bubble_cnt_q <= '0;
        end else begin
            wait_cnt_q   <= wait_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign wait_cnt   = wait_cnt_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb/tb_pipeline_sequencer.sv - directed self-checking bench for pipeline_sequencer
`timescale 1ns/1ps
module tb_pipeline_sequencer;

    logic        clk;
    logic        rst;
    logic        mem_ready;
    logic        ex_mem_mem_read;
    logic        ex_mem_mem_write;
    logic        id_ex_mem_read;
    logic [4:0]  id_ex_rd;
    logic [4:0]  if_id_rs1;
    logic [4:0]  if_id_rs2;
    logic        branch_taken;
    logic        halt_req;
    logic        mem_req;
    logic        mem_sel;
    logic        mem_we;
    logic        pc_en;
    logic        if_id_en;
    logic        pipe_en;
    logic        id_ex_bubble;
    logic        flush;
    logic        halted;
    logic [15:0] wait_cnt;
    logic [15:0] bubble_cnt;

    int tests;
    int fails;

    pipeline_sequencer #(.CNT_W(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_ready        (mem_ready),
        .ex_mem_mem_read  (ex_mem_mem_read),
        .ex_mem_mem_write (ex_mem_mem_write),
        .id_ex_mem_read   (id_ex_mem_read),
        .id_ex_rd         (id_ex_rd),
        .if_id_rs1        (if_id_rs1),
        .if_id_rs2        (if_id_rs2),
        .branch_taken     (branch_taken),
        .halt_req         (halt_req),
        .mem_req          (mem_req),
        .mem_sel          (mem_sel),
        .mem_we           (mem_we),
        .pc_en            (pc_en),
        .if_id_en         (if_id_en),
        .pipe_en          (pipe_en),
        .id_ex_bubble     (id_ex_bubble),
        .flush            (flush),
        .halted           (halted),
        .wait_cnt         (wait_cnt),
        .bubble_cnt       (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs the control outputs as {mem_req,mem_sel,mem_we,pc_en,if_id_en,pipe_en,bubble,flush,halted}
    function automatic logic [8:0] ctl();
        return {mem_req, mem_sel, mem_we, pc_en, if_id_en, pipe_en, id_ex_bubble, flush, halted};
    endfunction

    task automatic clear_inputs();
        mem_ready        = 1'b0;
        ex_mem_mem_read  = 1'b0;
        ex_mem_mem_write = 1'b0;
        id_ex_mem_read   = 1'b0;
        id_ex_rd         = 5'd0;
        if_id_rs1        = 5'd0;
        if_id_rs2        = 5'd0;
        branch_taken     = 1'b0;
        halt_req         = 1'b0;
    endtask

    // Leaves the DUT in the BOOT cycle just after rst release (at a negedge)
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if (ctl() !== 9'b0 || wait_cnt !== 16'd0 || bubble_cnt !== 16'd0) begin
            fails++;
            $display("FAIL reset_outputs: ctl=%b wait=%0d bub=%0d, required all 0", ctl(), wait_cnt, bubble_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (ctl() !== 9'b0) begin
            fails++;
            $display("FAIL boot_cycle: ctl=%b, required 000000000", ctl());
        end
    endtask

    task automatic test_fetch_stream();
        do_reset();
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            tests++;
            if (ctl() !== 9'b100111000) begin
                fails++;
                $display("FAIL fetch_stream[%0d]: ctl=%b, required 100111000", i, ctl());
            end
        end
        tests++;
        if (wait_cnt !== 16'd0) begin
            fails++;
            $display("FAIL fetch_stream_wait: wait_cnt=%0d, required 0", wait_cnt);
        end
    endtask

    task automatic test_load_store();
        do_reset();
        mem_ready       = 1'b1;
        ex_mem_mem_read = 1'b1;
        @(negedge clk);
        #1;
        tests++;
        if (ctl() !== 9'b100000000) begin
            fails++;
            $display("FAIL load_fetch_slot: ctl=%b, required 100000000", ctl());
        end
        @(negedge clk);
        #1;
        tests++;
        if (ctl() !== 9'b110111000) begin
            fails++;
            $display("FAIL load_data_slot: ctl=%b, required 110111000", ctl());
        end
        @(negedge clk);
        ex_mem_mem_read  = 1'b0;
        ex_mem_mem_write = 1'b1;
        #1;
        tests++;
        if (ctl() !== 9'b100000000) begin
            fails++;
            $display("FAIL store_fetch_slot: ctl=%b, required 100000000", ctl());
        end
        @(negedge clk);
        #1;
        tests++;
        if (ctl() !== 9'b111111000) begin
            fails++;
            $display("FAIL store_data_slot: ctl=%b, required 111111000", ctl());
        end
    endtask

    task automatic test_data_wait();
        int adv;
        adv = 0;
        do_reset();
        mem_ready       = 1'b1;
        ex_mem_mem_read = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            #1;
            adv += int'(pipe_en);
            tests++;
            if (ctl() !== 9'b110000000) begin
                fails++;
                $display("FAIL data_wait[%0d]: ctl=%b, required 110000000", i, ctl());
            end
        end
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        adv += int'(pipe_en);
        tests++;
        if (adv !== 1 || mem_sel !== 1'b1) begin
            fails++;
            $display("FAIL data_wait_advance: advances=%0d mem_sel=%b, required 1 and 1", adv, mem_sel);
        end
        tests++;
        if (wait_cnt !== 16'd3) begin
            fails++;
            $display("FAIL data_wait_cnt: wait_cnt=%0d, required 3", wait_cnt);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        mem_ready      = 1'b1;
        id_ex_mem_read = 1'b1;
        id_ex_rd       = 5'd5;
        if_id_rs1      = 5'd7;
        if_id_rs2      = 5'd5;
        @(negedge clk);
        #1;
        tests++;
        if (ctl() !== 9'b100001100) begin
            fails++;
            $display("FAIL load_use_bubble: ctl=%b, required 100001100", ctl());
        end
        @(negedge clk);
        id_ex_rd  = 5'd0;
        if_id_rs2 = 5'd0;
        #1;
        tests++;
        if (bubble_cnt !== 16'd1) begin
            fails++;
            $display("FAIL load_use_cnt: bubble_cnt=%0d, required 1", bubble_cnt);
        end
        tests++;
        if (ctl() !== 9'b100111000) begin
            fails++;
            $display("FAIL load_use_x0: ctl=%b, required 100111000", ctl());
        end
        @(negedge clk);
        #1;
        tests++;
        if (bubble_cnt !== 16'd1) begin
            fails++;
            $display("FAIL load_use_x0_cnt: bubble_cnt=%0d, required 1", bubble_cnt);
        end
    endtask

    task automatic test_branch_halt();
        do_reset();
        mem_ready      = 1'b1;
        branch_taken   = 1'b1;
        halt_req       = 1'b1;
        id_ex_mem_read = 1'b1;
        id_ex_rd       = 5'd9;
        if_id_rs1      = 5'd9;
        @(negedge clk);
        #1;
        tests++;
        if (ctl() !== 9'b100111010) begin
            fails++;
            $display("FAIL branch_priority: ctl=%b, required 100111010", ctl());
        end
        @(negedge clk);
        branch_taken   = 1'b0;
        id_ex_mem_read = 1'b0;
        #1;
        tests++;
        if (ctl() !== 9'b100111000 || bubble_cnt !== 16'd0) begin
            fails++;
            $display("FAIL halt_advance: ctl=%b bub=%0d, required 100111000 and 0", ctl(), bubble_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            tests++;
            if (ctl() !== 9'b000000001) begin
                fails++;
                $display("FAIL halted_hold[%0d]: ctl=%b, required 000000001", i, ctl());
            end
        end
    endtask

    task automatic test_wait_saturate_reset();
        do_reset();
        mem_ready = 1'b0;
        repeat (65535) @(negedge clk);
        #1;
        tests++;
        if (wait_cnt !== 16'hFFFE) begin
            fails++;
            $display("FAIL wait_preload: wait_cnt=%h, required fffe", wait_cnt);
        end
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (wait_cnt !== 16'hFFFF) begin
            fails++;
            $display("FAIL wait_saturate: wait_cnt=%h, required ffff", wait_cnt);
        end
        mem_ready       = 1'b1;
        ex_mem_mem_read = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        tests++;
        if (ctl() !== 9'b110000000 || wait_cnt !== 16'hFFFF) begin
            fails++;
            $display("FAIL wait_hold_in_data: ctl=%b wait=%h, required 110000000 and ffff", ctl(), wait_cnt);
        end
        #1;
        rst = 1'b1;
        #1;
        tests++;
        if (ctl() !== 9'b0 || wait_cnt !== 16'd0 || bubble_cnt !== 16'd0) begin
            fails++;
            $display("FAIL async_reset: ctl=%b wait=%h bub=%h, required all 0", ctl(), wait_cnt, bubble_cnt);
        end
        @(negedge clk);
        rst       = 1'b0;
        mem_ready = 1'b1;
        #1;
        tests++;
        if (mem_req !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_boot: mem_req=%b, required 0", mem_req);
        end
        @(negedge clk);
        #1;
        tests++;
        if (mem_req !== 1'b1 || mem_sel !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_fetch: mem_req=%b mem_sel=%b, required 1 and 0", mem_req, mem_sel);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_fetch_stream();
        test_load_store();
        test_data_wait();
        test_load_use();
        test_branch_halt();
        test_wait_saturate_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
